// File: rtl/sal_sched_pkg.sv
// Shared types and default inter-bank timing values for the channel command scheduler.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } sched_cmd_t;

  localparam int T_RRD_DEF = 2;
  localparam int T_CCD_DEF = 2;
  localparam int T_WTR_DEF = 3;
  localparam int T_RTW_DEF = 4;

endpackage

// File: rtl/sal_rr_arb.sv
// Round-robin arbiter: first set request at or above ptr_i (wrapping) wins.
module sal_rr_arb #(
  parameter int N = 8,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // N is a power of two, so the PW-bit add wraps naturally
      cand = ptr_i + PW'(i);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_timer.sv
// Inter-bank timing counter: loads t-1 on its command, counts down to 0 and holds.
// zero_o high means the constraint it guards is satisfied.
module sal_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] t_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (t_i == '0) ? '0 : t_i - TW'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sal_cmd_sched.sv
// Channel command scheduler: one combinational grant per cycle across all banks,
// honouring inter-bank tRRD/tCCD/tWTR/tRTW, with the command registered onto the bus.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int RA_W      = 14,
  parameter int CA_W      = 10,
  parameter int TW        = 4,
  localparam int BW       = $clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_BANKS-1:0]      act_req_i,
  input  logic [NUM_BANKS-1:0]      rd_req_i,
  input  logic [NUM_BANKS-1:0]      wr_req_i,
  input  logic [NUM_BANKS-1:0]      pre_req_i,
  input  logic [NUM_BANKS-1:0]      ref_req_i,
  input  logic [NUM_BANKS*RA_W-1:0] ra_i,
  input  logic [NUM_BANKS*CA_W-1:0] ca_i,
  output logic [NUM_BANKS-1:0]      act_gnt_o,
  output logic [NUM_BANKS-1:0]      rd_gnt_o,
  output logic [NUM_BANKS-1:0]      wr_gnt_o,
  output logic [NUM_BANKS-1:0]      pre_gnt_o,
  output logic [NUM_BANKS-1:0]      ref_gnt_o,
  input  logic [TW-1:0]             t_rrd_i,
  input  logic [TW-1:0]             t_ccd_i,
  input  logic [TW-1:0]             t_wtr_i,
  input  logic [TW-1:0]             t_rtw_i,
  output logic                      cmd_valid_o,
  output logic [2:0]                cmd_o,
  output logic [BW-1:0]             ba_o,
  output logic [RA_W-1:0]           addr_o
);

  logic rrd_ok, ccd_ok, wtr_ok, rtw_ok, rd_ok, wr_ok;
  logic [NUM_BANKS-1:0] col_req, act_req_m;
  logic [NUM_BANKS-1:0] ref_gnt, col_gnt, act_gnt, pre_gnt;
  logic [BW-1:0] ref_idx, col_idx, act_idx, pre_idx;
  logic ref_vld, col_vld, act_vld, pre_vld;

  logic [BW-1:0] rr_ptr_q, rr_ptr_d;
  logic          valid_q, valid_d;
  sched_cmd_t    cmd_q, cmd_d;
  logic [BW-1:0] ba_q, ba_d;
  logic [RA_W-1:0] addr_q, addr_d;

  logic       any_gnt;
  sched_cmd_t cmd_sel;
  logic [BW-1:0] bank_sel;

  assign rd_ok     = ccd_ok && wtr_ok;
  assign wr_ok     = ccd_ok && rtw_ok;
  // RD and WR share one arbiter so the nearest bank wins regardless of direction
  assign col_req   = (rd_req_i & {NUM_BANKS{rd_ok}}) | (wr_req_i & {NUM_BANKS{wr_ok}});
  assign act_req_m = act_req_i & {NUM_BANKS{rrd_ok}};

  sal_rr_arb #(.N(NUM_BANKS)) u_ref_arb (.req_i(ref_req_i), .ptr_i(rr_ptr_q), .gnt_o(ref_gnt), .idx_o(ref_idx), .vld_o(ref_vld));
  sal_rr_arb #(.N(NUM_BANKS)) u_col_arb (.req_i(col_req),   .ptr_i(rr_ptr_q), .gnt_o(col_gnt), .idx_o(col_idx), .vld_o(col_vld));
  sal_rr_arb #(.N(NUM_BANKS)) u_act_arb (.req_i(act_req_m), .ptr_i(rr_ptr_q), .gnt_o(act_gnt), .idx_o(act_idx), .vld_o(act_vld));
  sal_rr_arb #(.N(NUM_BANKS)) u_pre_arb (.req_i(pre_req_i), .ptr_i(rr_ptr_q), .gnt_o(pre_gnt), .idx_o(pre_idx), .vld_o(pre_vld));

  always_comb begin
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    any_gnt   = 1'b0;
    cmd_sel   = CMD_NOP;
    bank_sel  = '0;
    if (!rst_n) begin
      any_gnt = 1'b0;
    end else if (ref_vld) begin
      ref_gnt_o = ref_gnt;
      any_gnt   = 1'b1;
      cmd_sel   = CMD_REF;
      bank_sel  = ref_idx;
    end else if (col_vld) begin
      any_gnt  = 1'b1;
      bank_sel = col_idx;
      if (rd_req_i[col_idx] && rd_ok) begin
        rd_gnt_o = col_gnt;
        cmd_sel  = CMD_RD;
      end else begin
        wr_gnt_o = col_gnt;
        cmd_sel  = CMD_WR;
      end
    end else if (act_vld) begin
      act_gnt_o = act_gnt;
      any_gnt   = 1'b1;
      cmd_sel   = CMD_ACT;
      bank_sel  = act_idx;
    end else if (pre_vld) begin
      pre_gnt_o = pre_gnt;
      any_gnt   = 1'b1;
      cmd_sel   = CMD_PRE;
      bank_sel  = pre_idx;
    end
  end

  sal_timer #(.TW(TW)) u_rrd (.clk(clk), .rst_n(rst_n), .load_i(cmd_sel == CMD_ACT), .t_i(t_rrd_i), .zero_o(rrd_ok));
  sal_timer #(.TW(TW)) u_ccd (.clk(clk), .rst_n(rst_n), .load_i(cmd_sel == CMD_RD || cmd_sel == CMD_WR), .t_i(t_ccd_i), .zero_o(ccd_ok));
  sal_timer #(.TW(TW)) u_wtr (.clk(clk), .rst_n(rst_n), .load_i(cmd_sel == CMD_WR), .t_i(t_wtr_i), .zero_o(wtr_ok));
  sal_timer #(.TW(TW)) u_rtw (.clk(clk), .rst_n(rst_n), .load_i(cmd_sel == CMD_RD), .t_i(t_rtw_i), .zero_o(rtw_ok));

  always_comb begin
    rr_ptr_d = any_gnt ? bank_sel + BW'(1) : rr_ptr_q;
    valid_d  = any_gnt;
    cmd_d    = cmd_sel;
    ba_d     = bank_sel;
    addr_d   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel == BW'(b)) begin
        if (cmd_sel == CMD_ACT) begin
          addr_d = ra_i[b*RA_W +: RA_W];
        end else if (cmd_sel == CMD_RD || cmd_sel == CMD_WR) begin
          addr_d[CA_W-1:0] = ca_i[b*CA_W +: CA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      cmd_q    <= CMD_NOP;
      ba_q     <= '0;
      addr_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
    end
  end

  assign cmd_valid_o = valid_q;
  assign cmd_o       = cmd_q;
  assign ba_o        = ba_q;
  assign addr_o      = addr_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Directed bench for sal_cmd_sched: grants checked each cycle, bus words via a scoreboard queue.
module tb_sal_cmd_sched;
  import sal_sched_pkg::*;

  logic        clk, rst_n;
  logic [7:0]  act_req, rd_req, wr_req, pre_req, ref_req;
  logic [7:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [111:0] ra;
  logic [79:0]  ca;
  logic [3:0]  t_rrd, t_ccd, t_wtr, t_rtw;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [2:0]  ba;
  logic [13:0] addr;

  int vectors = 0;
  int miscompares = 0;
  logic [20:0] bus_q[$];

  sal_cmd_sched dut (
    .clk(clk), .rst_n(rst_n),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
    .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .ba_o(ba), .addr_o(addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] row_of(input int b);
    return 14'(14'h1555 ^ (b * 17));
  endfunction

  function automatic logic [9:0] col_of(input int b);
    return 10'(10'h2AA + b * 5);
  endfunction

  function automatic logic [39:0] gnt_exp(input logic [2:0] c, input int b);
    logic [7:0] oh;
    oh = 8'd1 << b;
    case (c)
      CMD_ACT: return {oh, 32'b0};
      CMD_RD:  return {8'b0, oh, 24'b0};
      CMD_WR:  return {16'b0, oh, 16'b0};
      CMD_PRE: return {24'b0, oh, 8'b0};
      CMD_REF: return {32'b0, oh};
      default: return 40'b0;
    endcase
  endfunction

  function automatic logic [20:0] bus_exp(input logic [2:0] c, input int b);
    logic [13:0] a;
    a = 14'b0;
    if (c == CMD_ACT) a = row_of(b);
    if (c == CMD_RD || c == CMD_WR) a = {4'b0, col_of(b)};
    if (c == CMD_NOP) return 21'b0;
    return {1'b1, c, 3'(b), a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] c, input int b);
    chk({tag, "_gnt"}, 64'({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}), 64'(gnt_exp(c, b)));
  endtask

  task automatic chk_bus_zero(input string tag);
    chk({tag, "_bus"}, 64'({cmd_valid, cmd, ba, addr}), 64'(0));
  endtask

  // Called just after a rising edge with inputs already driven
  task automatic step(input string tag, input logic [2:0] c, input int b);
    logic [20:0] exp;
    #1;
    chk_gnt(tag, c, b);
    bus_q.push_back(bus_exp(c, b));
    @(posedge clk);
    #1;
    if (bus_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      exp = bus_q.pop_front();
      chk({tag, "_bus"}, 64'({cmd_valid, cmd, ba, addr}), 64'(exp));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1; ref_req = '1;
    for (int b = 0; b < 8; b++) begin
      ra[b*14 +: 14] = row_of(b);
      ca[b*10 +: 10] = col_of(b);
    end
    t_rrd = 4'(T_RRD_DEF); t_ccd = 4'(T_CCD_DEF);
    t_wtr = 4'(T_WTR_DEF); t_rtw = 4'(T_RTW_DEF);

    // Reset holds everything quiet despite full requests
    #2;
    chk_gnt("rst_hold0", CMD_NOP, 0);
    chk_bus_zero("rst_hold0");
    @(posedge clk); #1;
    chk_gnt("rst_hold1", CMD_NOP, 0);
    chk_bus_zero("rst_hold1");
    rst_n = 1'b1;
    step("rst_first", CMD_REF, 0);
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;

    // Column class beats ACT; ACT round-robins from the moved pointer
    t_rrd = 4'd0; t_ccd = 4'd0; t_wtr = 4'd0; t_rtw = 4'd0;
    act_req = 8'b0010_0100; rd_req = 8'b0100_0000;
    step("prio_rd6", CMD_RD, 6);
    rd_req = '0;
    step("prio_act2", CMD_ACT, 2);
    act_req[2] = 1'b0;
    step("prio_act5", CMD_ACT, 5);
    act_req = '0;
    step("prio_idle", CMD_NOP, 0);

    // Park pointer at 0 via a bank-7 REF, then PRE round-robin with wrap
    ref_req = 8'h80;
    step("rr_ref7", CMD_REF, 7);
    ref_req = '0;
    pre_req = 8'hFF;
    for (int i = 0; i < 9; i++) step($sformatf("rr_pre%0d", i), CMD_PRE, i % 8);
    pre_req = '0;

    // tRRD=4
    t_rrd = 4'd4;
    act_req = 8'h01;
    step("rrd_act0", CMD_ACT, 0);
    act_req = 8'h02;
    for (int i = 1; i < 4; i++) step($sformatf("rrd_wait%0d", i), CMD_NOP, 0);
    step("rrd_act1", CMD_ACT, 1);
    act_req = '0;

    // tWTR=5, tCCD=2: RD waits for wtr
    t_wtr = 4'd5; t_ccd = 4'd2;
    wr_req = 8'h08;
    step("wtr_wr3", CMD_WR, 3);
    wr_req = '0; rd_req = 8'h10;
    for (int i = 1; i < 5; i++) step($sformatf("wtr_wait%0d", i), CMD_NOP, 0);
    step("wtr_rd4", CMD_RD, 4);
    rd_req = '0;
    step("wtr_gap0", CMD_NOP, 0);
    step("wtr_gap1", CMD_NOP, 0);

    // Same, but a WR arriving at n+2 slips past the blocked RD
    wr_req = 8'h08;
    step("wtr2_wr3", CMD_WR, 3);
    wr_req = '0; rd_req = 8'h10;
    step("wtr2_ccd", CMD_NOP, 0);
    wr_req = 8'h20;
    step("wtr2_wr5", CMD_WR, 5);
    wr_req = '0;
    for (int i = 3; i < 7; i++) step($sformatf("wtr2_wait%0d", i), CMD_NOP, 0);
    step("wtr2_rd4", CMD_RD, 4);
    rd_req = '0;

    // Async reset in the middle of back-to-back ACTs
    t_rrd = 4'd1;
    act_req = 8'hFF;
    step("ar_act5", CMD_ACT, 5);
    step("ar_act6", CMD_ACT, 6);
    t_rrd = 4'd8;
    step("ar_act7", CMD_ACT, 7);
    #1;
    chk_gnt("ar_blocked", CMD_NOP, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_gnt("ar_in_rst", CMD_NOP, 0);
    chk_bus_zero("ar_in_rst");
    t_rrd = 4'd4;
    @(posedge clk); #1;
    chk_bus_zero("ar_in_rst_edge");
    #1;
    rst_n = 1'b1;
    step("ar_act0", CMD_ACT, 0);
    for (int i = 1; i < 4; i++) step($sformatf("ar_wait%0d", i), CMD_NOP, 0);
    step("ar_act1", CMD_ACT, 1);
    act_req = '0;
    step("end_idle", CMD_NOP, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
